// File: rtl/z_run_pkg.sv
// Shared types and width constants for the z-run logger and its record FIFO.
// Z_RUN_LOGGER_TIMESTAMP_EN adds a start-cycle timestamp field to each record.
package z_run_pkg;

    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DROP_W     = 8;
    localparam int TS_W       = 16;

    localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

`ifdef Z_RUN_LOGGER_TIMESTAMP_EN
    typedef struct packed {
        logic             sat;
        logic [LEN_W-1:0] len;
        logic [TS_W-1:0]  ts;
    } rec_t;
`else
    typedef struct packed {
        logic             sat;
        logic [LEN_W-1:0] len;
    } rec_t;
`endif

endpackage

// File: rtl/z_run_fifo.sv
// First-word-fall-through record FIFO; flush outranks push and pop.
// The head reads as all zeros whenever the FIFO is empty.
module z_run_fifo
    import z_run_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  rec_t                     push_data,
    input  logic                     pop,
    input  logic                     flush,
    output rec_t                     head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/z_run_logger.sv
// Measures runs of z=1, queues {sat,len} records for a valid/ready reader, counts drops.
// Z_RUN_LOGGER_TIMESTAMP_EN adds a cycle counter and the rec_ts head-timestamp port.
module z_run_logger
    import z_run_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              z,
    input  logic              flush,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [LEN_W-1:0]  rec_len,
    output logic              rec_sat,
    output logic [DROP_W-1:0] drop_cnt
`ifdef Z_RUN_LOGGER_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]   rec_ts
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t           state;
    state_t           next_state;
    logic [LEN_W-1:0] run_len;
    logic             run_sat;
    logic             push_req;
    logic             pop_fire;
    logic             room;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    rec_t             push_rec;
    rec_t             head_rec;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    state <= IDLE;
        else if (flush) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (z)  next_state = RUN;
            RUN:     if (!z) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        push_req = 1'b0;
        if (state == RUN && !z && !flush) push_req = 1'b1;
    end

    // The length sticks at its maximum once reached; one more 1 marks it saturated.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_len <= '0;
            run_sat <= 1'b0;
        end else if (flush) begin
            run_len <= '0;
            run_sat <= 1'b0;
        end else if (state == IDLE && z) begin
            run_len <= LEN_W'(1);
            run_sat <= 1'b0;
        end else if (state == RUN && z) begin
            if (run_len == LEN_MAX) run_sat <= 1'b1;
            else                    run_len <= run_len + 1'b1;
        end
    end

    assign pop_fire = !fifo_empty && rec_ready && !flush;
    assign room     = (fifo_count != CNT_W'(DEPTH)) || pop_fire;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt <= '0;
        end else if (push_req && !room && drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef Z_RUN_LOGGER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_cnt   <= '0;
            ts_start <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (state == IDLE && z && !flush) ts_start <= ts_cnt;
        end
    end

    assign push_rec = '{sat: run_sat, len: run_len, ts: ts_start};
    assign rec_ts   = head_rec.ts;
`else
    assign push_rec = '{sat: run_sat, len: run_len};
`endif

    z_run_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_req && room),
        .push_data (push_rec),
        .pop       (rec_ready),
        .flush     (flush),
        .head      (head_rec),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rec_valid = !fifo_empty;
    assign rec_len   = head_rec.len;
    assign rec_sat   = head_rec.sat;

endmodule

// File: tb/tb_z_run_logger.sv
// Self-checking bench for z_run_logger: queue-based reference model plus directed scenarios.
// Builds with or without Z_RUN_LOGGER_TIMESTAMP_EN.
module tb_z_run_logger;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       z = 1'b0;
    logic       flush = 1'b0;
    logic       rec_ready = 1'b0;
    logic       rec_valid;
    logic [7:0] rec_len;
    logic       rec_sat;
    logic [7:0] drop_cnt;
`ifdef Z_RUN_LOGGER_TIMESTAMP_EN
    logic [15:0] rec_ts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    z_run_logger dut (
        .clk       (clk),
        .resetn    (resetn),
        .z         (z),
        .flush     (flush),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_len   (rec_len),
        .rec_sat   (rec_sat),
        .drop_cnt  (drop_cnt)
`ifdef Z_RUN_LOGGER_TIMESTAMP_EN
        ,
        .rec_ts    (rec_ts)
`endif
    );

    typedef struct {
        int len;
        bit sat;
        int ts;
    } rec_m_t;

    rec_m_t q[$];
    bit     in_run;
    int     run_n;
    int     run_ts;
    int     drops;
    int     cyc;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: true run length, saturation computed from it, records in a queue.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            in_run = 0;
            run_n  = 0;
            run_ts = 0;
            drops  = 0;
            cyc    = 0;
        end else begin
            bit     pop;
            rec_m_t r;
            pop = (q.size() > 0) && rec_ready;
            if (flush) begin
                q.delete();
                in_run = 0;
            end else begin
                if (in_run && !z) begin
                    r.len = (run_n > 255) ? 255 : run_n;
                    r.sat = (run_n > 255);
                    r.ts  = run_ts;
                    if (pop) void'(q.pop_front());
                    if (q.size() < 4) q.push_back(r);
                    else if (drops < 255) drops++;
                end else if (pop) begin
                    void'(q.pop_front());
                end
                if (z) begin
                    if (!in_run) begin
                        in_run = 1;
                        run_n  = 1;
                        run_ts = cyc;
                    end else begin
                        run_n++;
                    end
                end else begin
                    in_run = 0;
                end
            end
            cyc = (cyc + 1) % 65536;
        end
    end

    always begin
        @(negedge clk);
        #1;
        check_output("model_valid", rec_valid, (q.size() > 0) ? 1 : 0);
        check_output("model_len", rec_len, (q.size() > 0) ? q[0].len : 0);
        check_output("model_sat", rec_sat, (q.size() > 0) ? q[0].sat : 0);
        check_output("model_drop", drop_cnt, drops);
`ifdef Z_RUN_LOGGER_TIMESTAMP_EN
        check_output("model_ts", rec_ts, (q.size() > 0) ? q[0].ts : 0);
`endif
    end

    // Holds the given inputs across n posedges, returning on the following negedge.
    task automatic apply_stimulus(input bit zv, input bit rv, input bit fv, input int n = 1);
        repeat (n) begin
            z         = zv;
            rec_ready = rv;
            flush     = fv;
            @(negedge clk);
        end
    endtask

    task automatic run_of(input int n);
        apply_stimulus(1'b1, 1'b0, 1'b0, n);
        apply_stimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int popped;

        apply_stimulus(1'b0, 1'b0, 1'b0, 2);
        check_output("reset_valid", rec_valid, 0);
        check_output("reset_len", rec_len, 0);
        check_output("reset_drop", drop_cnt, 0);
        resetn = 1'b1;

        apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 3);
        check_output("t1_no_rec_yet", rec_valid, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("t1_valid", rec_valid, 1);
        check_output("t1_len", rec_len, 3);
        check_output("t1_sat", rec_sat, 0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("t1_popped", rec_valid, 0);

        run_of(300);
        check_output("t2_len300", rec_len, 255);
        check_output("t2_sat300", rec_sat, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        run_of(255);
        check_output("t2_len255", rec_len, 255);
        check_output("t2_sat255", rec_sat, 0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        run_of(1);
        check_output("t2_len1", rec_len, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0);

        repeat (6) run_of(2);
        check_output("t3_drop", drop_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            check_output("t3_pop_valid", rec_valid, 1);
            check_output("t3_pop_len", rec_len, 2);
            apply_stimulus(1'b0, 1'b1, 1'b0);
        end
        check_output("t3_empty", rec_valid, 0);

        repeat (4) run_of(2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 2);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("t4_drop_kept", drop_cnt, 2);
        popped = 0;
        for (int i = 0; i < 8 && rec_valid; i++) begin
            popped++;
            apply_stimulus(1'b0, 1'b1, 1'b0);
        end
        check_output("t4_count", popped, 4);

        apply_stimulus(1'b1, 1'b0, 1'b0, 4);
        resetn = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        resetn = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 2);
        check_output("t5_valid", rec_valid, 0);
        check_output("t5_len", rec_len, 0);
        check_output("t5_drop", drop_cnt, 0);

        repeat (5) run_of(2);
        check_output("t6_drop_pre", drop_cnt, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 2);
        check_output("t6_two_held", rec_valid, 1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_output("t6_flushed", rec_valid, 0);
        check_output("t6_drop_kept", drop_cnt, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 2);
        check_output("t6_run_abandoned", rec_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
